// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction memory read handshake between the fetch unit and memory.
//   mem_req   : read request, held high while a read is outstanding
//   mem_addr  : read address, stable while mem_req is high
//   mem_ack   : read acknowledge, mem_rdata valid in the same cycle
//   mem_rdata : read data
// master modport = fetch unit side, slave modport = memory side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Downstream stage of the S-Machine main state machine. Each rising edge on
// start fetches one 16-bit instruction word from address pc over a req/ack
// handshake, splits it into opcode/operand and pulses done for one cycle.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start, pc   : fetch request (edge detected) and fetch address
//   mem         : memory read handshake (master side)
//   instr, opcode, operand, instr_valid : last fetched word and its fields
//   done        : one-cycle completion pulse (also on timeout)
//   busy        : high whenever not idle
//   timeout_err : last fetch aborted because mem_ack never came
//   drop_err    : sticky, a start edge arrived while busy
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   pc,
    instr_fetch_unit_if.master  mem,
    output logic [DATA_W-1:0]   instr,
    output logic [3:0]          opcode,
    output logic [11:0]         operand,
    output logic                instr_valid,
    output logic                done,
    output logic                busy,
    output logic                timeout_err,
    output logic                drop_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DECODE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Last counter value allowed in REQ before giving up on mem_ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               start_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [11:0]        operand_q, operand_d;
    logic               valid_q, valid_d;
    logic               terr_q, terr_d;
    logic               drop_q, drop_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               start_rise_s;

    assign start_rise_s = start & ~start_q;

    // Next-state and next-output computation for the fetch sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        valid_d   = valid_q;
        terr_d    = terr_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise_s) begin
                    addr_d  = pc;
                    terr_d  = 1'b0;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                opcode_d  = instr_q[15:12];
                operand_d = instr_q[11:0];
                valid_d   = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A start edge seen while busy is only recorded; the fetch continues.
        if (start_rise_s && (state_q != S_IDLE)) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        req_d  = (state_d == S_REQ);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any fetch immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            cnt_q     <= 8'd0;
            addr_q    <= '0;
            instr_q   <= '0;
            opcode_q  <= 4'd0;
            operand_q <= 12'd0;
            valid_q   <= 1'b0;
            terr_q    <= 1'b0;
            drop_q    <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            valid_q   <= valid_d;
            terr_q    <= terr_d;
            drop_q    <= drop_d;
            req_q     <= req_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign instr        = instr_q;
    assign opcode       = opcode_q;
    assign operand      = operand_q;
    assign instr_valid  = valid_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;
    assign drop_err     = drop_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. The bench plays the memory side of the
// handshake by hand; a negedge monitor counts done pulses, mem_req cycles and
// mem_addr deviations from the address the bench expects.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        instr_valid, done, busy, timeout_err, drop_err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    int addr_bad = 0;
    logic [7:0] exp_addr = 8'h00;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) mif ();

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pc          (pc),
        .mem         (mif.master),
        .instr       (instr),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .drop_err    (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle observation in the middle of each cycle.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (mif.mem_req) begin
            req_cnt = req_cnt + 1;
            if (mif.mem_addr !== exp_addr) addr_bad = addr_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        done_cnt = 0;
        req_cnt  = 0;
        addr_bad = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pc    = 8'h00;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0000;
        #22;
        chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_drop", {31'd0, drop_err}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Zero-wait fetch: pc=0x05, data 0xA3C7.
        clr();
        exp_addr = 8'h05; pc = 8'h05;
        mif.mem_rdata = 16'hA3C7; mif.mem_ack = 1'b1;
        start = 1'b1;
        step();                                // sampling edge E
        chk("t1_req", {31'd0, mif.mem_req}, 32'd1);
        chk("t1_addr", {24'd0, mif.mem_addr}, 32'h05);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        step();                                // E+1: DECODE
        chk("t1_req_low", {31'd0, mif.mem_req}, 32'd0);
        chk("t1_done_early", {31'd0, done}, 32'd0);
        mif.mem_ack = 1'b0;
        step();                                // E+2: DONE
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_opcode", {28'd0, opcode}, 32'hA);
        chk("t1_operand", {20'd0, operand}, 32'h3C7);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        step();                                // E+3: IDLE
        chk("t1_done_low", {31'd0, done}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_req_cnt", req_cnt, 32'd1);
        chk("t1_done_cnt", done_cnt, 32'd1);

        // Ack delayed 4 cycles: pc=0x10, data 0x1FFF; pc changed after accept.
        clr();
        exp_addr = 8'h10; pc = 8'h10;
        mif.mem_rdata = 16'h1FFF;
        start = 1'b1;
        step();                                // E
        start = 1'b0; pc = 8'h77;
        repeat (4) step();                     // E+4
        mif.mem_ack = 1'b1;
        step();                                // E+5: DECODE
        mif.mem_ack = 1'b0;
        chk("t2_req_low", {31'd0, mif.mem_req}, 32'd0);
        step();                                // E+6: DONE
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_instr", {16'd0, instr}, 32'h1FFF);
        step();                                // E+7
        chk("t2_done_low", {31'd0, done}, 32'd0);
        chk("t2_req_cnt", req_cnt, 32'd5);
        chk("t2_addr_stable", addr_bad, 32'd0);
        chk("t2_done_cnt", done_cnt, 32'd1);

        // Timeout: no ack at all.
        clr();
        exp_addr = 8'h20; pc = 8'h20;
        start = 1'b1;
        step();                                // E
        start = 1'b0;
        repeat (15) step();                    // E+15: DONE
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_terr", {31'd0, timeout_err}, 32'd1);
        chk("t3_valid", {31'd0, instr_valid}, 32'd0);
        chk("t3_instr_kept", {16'd0, instr}, 32'h1FFF);
        step();
        chk("t3_req_cnt", req_cnt, 32'd15);
        chk("t3_done_cnt", done_cnt, 32'd1);
        // Next successful start clears timeout_err.
        clr();
        exp_addr = 8'h03; pc = 8'h03;
        mif.mem_rdata = 16'h5123; mif.mem_ack = 1'b1;
        start = 1'b1;
        step();
        chk("t3_terr_clr", {31'd0, timeout_err}, 32'd0);
        start = 1'b0;
        repeat (3) step();
        mif.mem_ack = 1'b0;
        chk("t3b_instr", {16'd0, instr}, 32'h5123);
        chk("t3b_valid", {31'd0, instr_valid}, 32'd1);
        chk("t3b_done_cnt", done_cnt, 32'd1);

        // Second start edge while in REQ is dropped.
        clr();
        exp_addr = 8'h08; pc = 8'h08;
        mif.mem_rdata = 16'h2468;
        start = 1'b1;
        step();                                // E
        start = 1'b0; pc = 8'h44;
        step();
        start = 1'b1;
        step();                                // rise seen while busy
        chk("t4_drop", {31'd0, drop_err}, 32'd1);
        start = 1'b0; mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        repeat (3) step();
        chk("t4_instr", {16'd0, instr}, 32'h2468);
        chk("t4_addr_stable", addr_bad, 32'd0);
        chk("t4_done_cnt", done_cnt, 32'd1);
        chk("t4_drop_sticky", {31'd0, drop_err}, 32'd1);

        // Reset asserted mid-REQ.
        clr();
        exp_addr = 8'h30; pc = 8'h30;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_req_before", {31'd0, mif.mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_req_async", {31'd0, mif.mem_req}, 32'd0);
        chk("t5_busy_async", {31'd0, busy}, 32'd0);
        chk("t5_valid_async", {31'd0, instr_valid}, 32'd0);
        chk("t5_drop_rst", {31'd0, drop_err}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("t5_no_done", done_cnt, 32'd0);
        clr();
        exp_addr = 8'h02; pc = 8'h02;
        mif.mem_rdata = 16'h0ABC; mif.mem_ack = 1'b1;
        start = 1'b1;
        step();
        chk("t5_addr", {24'd0, mif.mem_addr}, 32'h02);
        start = 1'b0;
        repeat (3) step();
        mif.mem_ack = 1'b0;
        chk("t5_opcode", {28'd0, opcode}, 32'h0);
        chk("t5_operand", {20'd0, operand}, 32'hABC);
        chk("t5_done_cnt", done_cnt, 32'd1);

        // start held high for 20 cycles.
        clr();
        exp_addr = 8'h09; pc = 8'h09;
        mif.mem_rdata = 16'h7001; mif.mem_ack = 1'b1;
        start = 1'b1;
        repeat (20) step();
        start = 1'b0;
        repeat (2) step();
        mif.mem_ack = 1'b0;
        chk("t6_done_cnt", done_cnt, 32'd1);
        chk("t6_req_cnt", req_cnt, 32'd1);
        chk("t6_drop", {31'd0, drop_err}, 32'd0);
        chk("t6_instr", {16'd0, instr}, 32'h7001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Downstream stage of the S-Machine main state machine: consumes its start pulse and 8-bit count (used as the program counter) and returns done.
- Per start: fetches one 16-bit instruction word over a req/ack memory handshake, splits it into opcode and operand, then pulses done so the main state machine can issue the next start.
- Single clock domain; the only source of back-pressure upstream is done.

Parameters:
- ADDR_W, 8, width of pc and mem_addr (matches upstream count width).
- DATA_W, 16, width of the instruction word; fixed at 16 for the decode field split.
- TIMEOUT, 15, maximum cycles in REQ without mem_ack before aborting; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  fetch request from main state machine; sampled on clk, rising edge detected.
- pc  in  ADDR_W  fetch address; sampled on the accepted start edge.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  memory read acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- instr  out  DATA_W  last fetched instruction word.
- opcode  out  4  instr[15:12].
- operand  out  12  instr[11:0].
- instr_valid  out  1  instr/opcode/operand hold a successfully fetched word.
- done  out  1  one-cycle completion pulse to the main state machine.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  last fetch aborted by timeout.
- drop_err  out  1  sticky: a start edge arrived while busy.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; start_q=0; timeout counter=0. mem_req drops immediately, without waiting for a clock edge. A fetch in progress is abandoned with no done pulse.
- start edge detection: start_q<=start on every edge; start_rise=start&~start_q.
  - Because start_q resets to 0, start held high across reset release is accepted once at the first edge.
  - start held high generates only one start_rise.
- States: IDLE, REQ, DECODE, DONE. busy=(state!=IDLE).
- IDLE:
  - On start_rise: mem_addr<=pc; timeout_err<=0; instr_valid<=0; counter<=0; ->REQ.
  - Otherwise stay.
- REQ:
  - mem_req=1 (registered output, high for the entire REQ state).
  - mem_ack=1 at an edge: instr<=mem_rdata; ->DECODE; mem_req low from the next cycle.
  - Else if counter==TIMEOUT-1: timeout_err<=1; ->DONE; instr and instr_valid unchanged (0).
  - Else counter<=counter+1.
  - mem_ack while not in REQ is ignored.
- DECODE (1 cycle): opcode<=instr[15:12]; operand<=instr[11:0]; instr_valid<=1; ->DONE.
- DONE (1 cycle): done=1; ->IDLE. done is high for exactly one cycle per accepted start, including timeouts.
- Latency: with ack in the first REQ cycle, the sequence after the sampling edge E is:
  - REQ in cycle E..E+1.
  - DECODE in cycle E+1..E+2.
  - done high in cycle E+2..E+3.
  - IDLE at E+3.
  - Each wait cycle of ack adds 1.
- Back-to-back: a start_rise in the same cycle that done is high is dropped because busy=1, setting drop_err. A start_rise in the IDLE cycle immediately after done is accepted.
- drop_err: set on start_rise while busy; cleared only by reset. A dropped start does not disturb the fetch in progress.
- instr, opcode and operand hold their values until the next successful fetch. instr_valid stays 1 until the next accepted start.
- pc changes after the accepted edge do not affect mem_addr.

Test Plan:
- Reset then start pulse with pc=0x05, memory returns 0xA3C7 with zero wait:
  - mem_req high 1 cycle with mem_addr=0x05.
  - done pulses 3 cycles after the sampling edge.
  - opcode=0xA, operand=0x3C7, instr_valid=1.
- Ack delayed 4 cycles, pc=0x10, data 0x1FFF:
  - mem_req high 5 cycles, mem_addr stable at 0x10 throughout.
  - done 7 cycles after the start edge; instr=0x1FFF.
- No ack with TIMEOUT=15:
  - mem_req high exactly 15 cycles, then done pulses.
  - timeout_err=1, instr_valid=0.
  - The next successful start clears timeout_err.
- Second start pulse while in REQ:
  - drop_err=1 and stays 1.
  - The first fetch completes normally; exactly one done pulse.
- rst_n asserted mid-REQ:
  - mem_req, busy and instr_valid go 0 asynchronously; no done pulse.
  - After release, start with pc=0x02 fetches normally.
- start held high for 20 cycles: exactly one fetch and one done pulse; drop_err stays 0.
